// File: rtl/emotion_stabilizer.sv
// Emotion-code debouncer: commits a 3-bit classification only after
// STABLE_COUNT consecutive identical valid samples. Out-of-range codes
// (> 3'b011) are mapped to 3'b000 and flagged with sample_err.
// Optional idle timeout is compiled in with macro STABILIZER_TIMEOUT_EN;
// without it the block has no idle counter and timeout is tied low.
module emotion_stabilizer #(
  parameter int STABLE_COUNT   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw_code,
  input  logic       raw_valid,
  output logic [2:0] emotion_code,
  output logic       code_changed,
  output logic       stable,
  output logic       sample_err,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LP_SC = 4'(STABLE_COUNT);

  // Reject illegal parameter values at elaboration time.
  generate
    if (STABLE_COUNT < 1 || STABLE_COUNT > 15 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("emotion_stabilizer: parameter out of legal range");
    end
  endgenerate

  state_t     r_state;
  state_t     w_state_nx;
  logic [2:0] r_cand;
  logic [2:0] w_cand_nx;
  logic [3:0] r_count;
  logic [3:0] w_count_nx;
  logic [2:0] r_code;
  logic [2:0] w_code_nx;
  logic       w_commit;

  logic       r_changed;
  logic       r_stable;
  logic       r_err;
  logic       w_changed_nx;
  logic       w_stable_nx;
  logic       w_err_nx;

  logic       w_bad;
  logic [2:0] w_sample;
  logic       w_fire;

  // Out-of-range codes collapse to neutral before any comparison.
  assign w_bad    = (raw_code > 3'b011);
  assign w_sample = w_bad ? 3'b000 : raw_code;

`ifdef STABILIZER_TIMEOUT_EN
  localparam logic [15:0] LP_TO = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_idle;
  logic        r_timeout;

  // A valid sample in the firing cycle wins, so the timeout only fires
  // on an idle cycle that completes the count.
  assign w_fire = !raw_valid && (r_idle == LP_TO - 16'd1);

  // Idle counter: clears on valid, parks at LP_TO after firing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle    <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_fire;
      if (raw_valid) begin
        r_idle <= 16'd0;
      end else if (r_idle != LP_TO) begin
        r_idle <= r_idle + 16'd1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_fire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // State and datapath registers, plus the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_cand    <= 3'b000;
      r_count   <= 4'd0;
      r_code    <= 3'b000;
      r_changed <= 1'b0;
      r_stable  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cand    <= w_cand_nx;
      r_count   <= w_count_nx;
      r_code    <= w_code_nx;
      r_changed <= w_changed_nx;
      r_stable  <= w_stable_nx;
      r_err     <= w_err_nx;
    end
  end

  // Next-state: run tracking, commit on reaching STABLE_COUNT, idle revert.
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_count_nx = r_count;
    w_code_nx  = r_code;
    w_commit   = 1'b0;
    if (raw_valid) begin
      if (r_state == ST_EMPTY || w_sample != r_cand) begin
        // Start a new run; a run of one already qualifies when STABLE_COUNT is 1.
        w_cand_nx  = w_sample;
        w_count_nx = 4'd1;
        if (LP_SC == 4'd1) begin
          w_state_nx = ST_LOCKED;
          w_commit   = 1'b1;
        end else begin
          w_state_nx = ST_QUALIFY;
        end
      end else if (r_state == ST_QUALIFY) begin
        w_count_nx = r_count + 4'd1;
        if (r_count + 4'd1 == LP_SC) begin
          w_state_nx = ST_LOCKED;
          w_commit   = 1'b1;
        end
      end
      // LOCKED with an equal sample: count stays saturated.
    end else if (w_fire) begin
      w_state_nx = ST_EMPTY;
      w_cand_nx  = 3'b000;
      w_count_nx = 4'd0;
      w_code_nx  = 3'b000;
    end
    if (w_commit) begin
      w_code_nx = w_cand_nx;
    end
  end

  // Output decode: flags derived from next-state values, registered above.
  always_comb begin
    w_changed_nx = (w_code_nx != r_code);
    w_stable_nx  = (w_state_nx == ST_LOCKED) && (w_cand_nx == w_code_nx);
    w_err_nx     = raw_valid && w_bad;
  end

  assign emotion_code = r_code;
  assign code_changed = r_changed;
  assign stable       = r_stable;
  assign sample_err   = r_err;

endmodule

// File: doc/emotion_stabilizer.md
EMOTION_STABILIZER -- requirements
Module: emotion_stabilizer

Interface
REQ-001 Parameter STABLE_COUNT, default 4: number of consecutive identical valid samples required to commit a code; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: idle cycles without raw_valid before reverting to IDLE; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 raw_code  input  3  unfiltered emotion classification sample.
REQ-006 raw_valid  input  1  raw_code is valid this cycle; there is no backpressure, so every valid sample SHALL be consumed.
REQ-007 emotion_code  output  3  committed, debounced code feeding the downstream desk FSM.
REQ-008 code_changed  output  1  one-cycle pulse when emotion_code takes a new value.
REQ-009 stable  output  1  high while in LOCKED with candidate equal to emotion_code.
REQ-010 sample_err  output  1  one-cycle pulse on a valid sample with raw_code > 3'b011.
REQ-011 timeout  output  1  one-cycle pulse when the idle timeout fires; it SHALL be tied 0 when the feature is compiled out.

Function
REQ-012 A valid raw_code above 3'b011 SHALL be mapped to 3'b000 before any comparison, and sample_err SHALL pulse in the following cycle.
REQ-013 The block SHALL hold three states: EMPTY (no candidate), QUALIFY (candidate with count < STABLE_COUNT), and LOCKED (count == STABLE_COUNT).
REQ-014 In EMPTY, a valid sample SHALL set candidate to the sample and count to 1, then move to QUALIFY; if STABLE_COUNT == 1 it SHALL move directly to LOCKED and commit.
REQ-015 In QUALIFY, a valid sample equal to candidate SHALL increment count; a differing sample SHALL reload candidate and set count to 1.
REQ-016 When count reaches STABLE_COUNT, the state SHALL become LOCKED, and emotion_code SHALL load candidate on that same edge.
REQ-017 Commit latency SHALL be one cycle: the qualifying sample at edge N is visible on emotion_code after edge N.
REQ-018 code_changed SHALL pulse only if the committed value differs from the previous emotion_code; re-committing the same value SHALL NOT pulse.
REQ-019 In LOCKED, an equal sample SHALL leave count saturated at STABLE_COUNT.
REQ-020 In LOCKED, a differing sample SHALL reload candidate with count 1, return to QUALIFY, and leave emotion_code unchanged.
REQ-021 Cycles with raw_valid low SHALL hold candidate, count, state and emotion_code, and gaps between valid samples SHALL NOT break a run.
REQ-022 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-023 When reset is high at a clock edge, the block SHALL force state EMPTY, candidate 3'b000, count 0, and the idle counter 0.
REQ-024 The same reset edge SHALL force emotion_code 3'b000, code_changed 0, stable 0, sample_err 0, and timeout 0.
REQ-025 Reset asserted mid-qualification SHALL discard the partial run, and reset SHALL take priority over raw_valid.

Configuration
REQ-026 With macro STABILIZER_TIMEOUT_EN defined, an idle counter SHALL count cycles with raw_valid low and clear on any valid sample.
REQ-027 With the macro defined, on reaching TIMEOUT_CYCLES the block SHALL pulse timeout and force state EMPTY, candidate 3'b000, count 0, and emotion_code 3'b000.
REQ-028 With the macro defined, the timeout SHALL pulse code_changed if emotion_code was nonzero, and the counter SHALL then stop until the next valid sample.
REQ-029 With the macro defined, raw_valid in the cycle the timeout would fire SHALL win: the sample is processed normally and no timeout occurs.
REQ-030 Without the macro, the block SHALL contain no idle counter, emotion_code SHALL hold indefinitely, and timeout SHALL be constantly 0.

Verification
REQ-031 Reset, then four consecutive valid 3'b010 -> emotion_code = 3'b010 one cycle after the 4th sample, one code_changed pulse, stable = 1.
REQ-032 Valid samples 001, 001, 001, 011, 001, 001, 001, 001 -> emotion_code stays 000 until the 8th sample, then becomes 001; exactly one code_changed.
REQ-033 Valid 3'b110 x4 with emotion_code = 001 -> four sample_err pulses, emotion_code becomes 000, one code_changed.
REQ-034 Locked at 011 with STABILIZER_TIMEOUT_EN defined and TIMEOUT_CYCLES = 10, raw_valid low for 10 cycles -> timeout and code_changed pulse together, and emotion_code = 000.
REQ-035 Valid arrives in the exact cycle the timeout would fire -> no timeout pulse, and emotion_code is unchanged.
REQ-036 Reset asserted after 3 of 4 qualifying samples, then 1 further sample -> emotion_code stays 000 and state is QUALIFY with count 1.
